// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states, port owners
// and the legal range of the memory read latency.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between the fetch port and the
// load/store port; data wins ties, but a pending fetch always gets the next grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall_f,
  output logic                  stall_m
);

  localparam bit          LAT_OK   = mem_lat_ok(MEM_LAT);
  localparam logic [2:0]  LAT_INIT = 3'(MEM_LAT);

  if (!LAT_OK) begin : g_lat_chk
    $error("mem_arbiter: MEM_LAT must be in 1..7");
  end
  if ((DATA_W % 8) != 0) begin : g_width_chk
    $error("mem_arbiter: DATA_W must be a multiple of 8");
  end

  state_e     state;
  logic       owner;
  logic       fetch_next;
  logic       is_write;
  logic [2:0] counter;
  logic       grant_d;
  logic       grant_f;

  // A fetch that lost the previous tie takes priority over the next data request.
  always_comb begin
    grant_d = d_req & ~(if_req & fetch_next);
    grant_f = if_req & ~grant_d;
  end

  assign stall_f = if_req & ~if_valid;
  assign stall_m = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_FETCH;
      fetch_next <= 1'b0;
      is_write   <= 1'b0;
      counter    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d | grant_f) begin
            owner     <= grant_d ? OWN_DATA : OWN_FETCH;
            mem_addr  <= grant_d ? d_addr : if_addr;
            is_write  <= grant_d & d_we;
            mem_we    <= grant_d & d_we;
            mem_wstrb <= (grant_d & d_we) ? d_wstrb : '0;
            if (grant_d & d_we) mem_wdata <= d_wdata;
            mem_en    <= 1'b1;
            counter   <= LAT_INIT;
            state     <= ST_ACCESS;
            if (grant_f)     fetch_next <= 1'b0;
            else if (if_req) fetch_next <= 1'b1;
          end
        end
        ST_ACCESS: begin
          // Strobes live only in the issue cycle; address and write data stay put.
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_wstrb <= '0;
          if (counter == 3'd0) begin
            if (owner == OWN_DATA) begin
              d_valid <= 1'b1;
              if (!is_write) d_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
            state <= ST_DONE;
          end else begin
            counter <= counter - 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing scenarios plus randomized
// fetch/load/store traffic checked against a word-level memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        d_valid;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        stall_f, stall_m;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  // Second instance with a three-cycle memory.
  logic        i3_req = 1'b0;
  logic [31:0] i3_addr = '0, i3_rdata;
  logic        i3_valid;
  logic        d3_req, d3_we;
  logic [31:0] d3_addr, d3_rdata;
  logic [31:0] d3_wdata = '0;
  logic [3:0]  d3_wstrb = '0;
  logic        d3_valid;
  logic        m3_en, m3_we;
  logic [31:0] m3_addr, m3_wdata, m3_rdata;
  logic [3:0]  m3_wstrb;
  logic        s3_f, s3_m;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(i3_req), .if_addr(i3_addr), .if_rdata(i3_rdata), .if_valid(i3_valid),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata), .d_wstrb(d3_wstrb),
    .d_rdata(d3_rdata), .d_valid(d3_valid),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_wstrb(m3_wstrb), .mem_rdata(m3_rdata),
    .stall_f(s3_f), .stall_m(s3_m)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory device: one-cycle read latency, junk on the bus when no read is due.
  logic [31:0] mem_arr [4096];
  bit          wr_v    [4096];
  logic        rv = 1'b0;
  logic [31:0] rd;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return wr_v[a[13:2]] ? mem_arr[a[13:2]] : init_word(a);
  endfunction

  always @(posedge clk) begin
    rv <= mem_en & ~mem_we;
    rd <= mem_read(mem_addr);
    if (mem_en & mem_we) begin
      mem_arr[mem_addr[13:2]] <= merge(mem_read(mem_addr), mem_wdata, mem_wstrb);
      wr_v[mem_addr[13:2]]    <= 1'b1;
    end
  end
  assign mem_rdata = rv ? rd : 32'hBAD0_BAD0;

  logic [2:0]       v3 = '0;
  logic [2:0][31:0] p3;
  always @(posedge clk) begin
    v3 <= {v3[1:0], m3_en};
    p3 <= {p3[1:0], init_word(m3_addr)};
  end
  assign m3_rdata = v3[2] ? p3[2] : 32'hBAD0_BAD0;

  // Reference model and scoreboard state
  logic [31:0] ref_mem [4096];
  logic [31:0] d_last;
  logic [31:0] f_exp[$];
  logic [31:0] d_exp[$];
  typedef struct { int cyc; logic [31:0] addr; logic we; logic [3:0] strb; } iss_t;
  iss_t issue_log[$];
  int   fv_cyc[$], dv_cyc[$], sf_cyc[$];
  int   cyc = 0;
  int   cmp = 0;
  int   nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999;
  endfunction

  task automatic clear_logs();
    issue_log.delete(); fv_cyc.delete(); dv_cyc.delete(); sf_cyc.delete();
  endtask

  // Monitor: pops expected responses, checks grant policy and strobe width.
  initial begin
    logic prev_en, pf, pd, must_f, own, exp_own;
    prev_en = 0; pf = 0; pd = 0; must_f = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 0; pf = 0; pd = 0; must_f = 0;
      end else begin
        if (if_valid) begin
          fv_cyc.push_back(cyc);
          if (f_exp.size() == 0) begin
            cmp++; nfail++;
            $display("FAIL if_valid_unexpected: got pulse with if_rdata=%0h, expected none", if_rdata);
          end else check("if_rdata", if_rdata, f_exp.pop_front());
        end
        if (d_valid) begin
          dv_cyc.push_back(cyc);
          if (d_exp.size() == 0) begin
            cmp++; nfail++;
            $display("FAIL d_valid_unexpected: got pulse with d_rdata=%0h, expected none", d_rdata);
          end else check("d_rdata", d_rdata, d_exp.pop_front());
        end
        if (stall_f) sf_cyc.push_back(cyc);
        if (mem_en) begin
          check("mem_en_single_cycle", prev_en, 1'b0);
          own     = (mem_addr >= 32'h1000);
          exp_own = pd && !(pf && must_f);
          check("grant_owner", own, exp_own);
          if (own && pf) must_f = 1;
          else if (!own) must_f = 0;
          issue_log.push_back('{cyc, mem_addr, mem_we, mem_wstrb});
        end
        prev_en = mem_en; pf = if_req; pd = d_req;
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a);
    int n;
    if_req = 1'b1; if_addr = a;
    f_exp.push_back(ref_mem[a[13:2]]);
    n = 0;
    do begin @(negedge clk); n++; end while (!if_valid && n < 60);
    if (!if_valid) begin
      cmp++; nfail++;
      $display("FAIL fetch_timeout: addr %0h got no if_valid, required within 60 cycles", a);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st);
    int n;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = st;
    if (we) ref_mem[a[13:2]] = merge(ref_mem[a[13:2]], wd, st);
    else    d_last = ref_mem[a[13:2]];
    d_exp.push_back(d_last);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_valid && n < 60);
    if (!d_valid) begin
      cmp++; nfail++;
      $display("FAIL data_timeout: addr %0h got no d_valid, required within 60 cycles", a);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [4:0] ord;
    logic [7:0] en_mask;
    int v_at;
    logic [31:0] v_dat;

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(32'(i) << 2);
    d_last = '0;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    d3_req = 0; d3_we = 0; d3_addr = '0;

    repeat (2) @(posedge clk); #1;
    check("rst_valids", {if_valid, d_valid, stall_f, stall_m}, '0);
    check("rst_mem_ctl", {mem_en, mem_we, mem_wstrb}, '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_rdata", {if_rdata, d_rdata}, '0);
    rst_n = 1'b1;

    // Fetch only
    @(posedge clk); #1;
    clear_logs(); t0 = cyc;
    do_fetch(32'h100);
    check("t1_issue_count", issue_log.size(), 1);
    if (issue_log.size() > 0) begin
      check("t1_issue_cycle", issue_log[0].cyc - t0, 1);
      check("t1_issue_addr", issue_log[0].addr, 32'h100);
    end
    check("t1_valid_cycle", at(fv_cyc, 0) - t0, 3);
    check("t1_stall_count", sf_cyc.size(), 3);
    check("t1_stall_first", at(sf_cyc, 0) - t0, 0);
    check("t1_stall_last", at(sf_cyc, 2) - t0, 2);

    // Store, then read back the merged word
    clear_logs(); t0 = cyc;
    do_data(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011);
    check("t2_issue_count", issue_log.size(), 1);
    if (issue_log.size() > 0) begin
      check("t2_issue_cycle", issue_log[0].cyc - t0, 1);
      check("t2_issue_we", issue_log[0].we, 1'b1);
      check("t2_issue_strb", issue_log[0].strb, 4'b0011);
    end
    check("t2_valid_cycle", at(dv_cyc, 0) - t0, 3);
    do_data(1'b0, 32'h2004, '0, '0);

    // Simultaneous fetch and load
    clear_logs(); t0 = cyc;
    fork
      do_fetch(32'h40);
      do_data(1'b0, 32'h3000, '0, '0);
    join
    check("t3_issue_count", issue_log.size(), 2);
    if (issue_log.size() > 1) begin
      check("t3_first_addr", issue_log[0].addr, 32'h3000);
      check("t3_second_cycle", issue_log[1].cyc - t0, 5);
    end
    check("t3_d_valid_cycle", at(dv_cyc, 0) - t0, 3);
    check("t3_f_valid_cycle", at(fv_cyc, 0) - t0, 7);

    // Held data requests against a pending fetch
    clear_logs();
    fork
      begin do_fetch(32'h80); do_fetch(32'h84); end
      begin for (int k = 0; k < 3; k++) do_data(1'b0, 32'h2010 + 32'(4*k), '0, '0); end
    join
    ord = '0;
    foreach (issue_log[i]) ord = {ord[3:0], issue_log[i].addr >= 32'h1000};
    check("t4_grant_count", issue_log.size(), 5);
    check("t4_grant_order", ord, 5'b10101);

    // Reset during the second access cycle
    if_req = 1'b1; if_addr = 32'h104;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctl", {if_valid, d_valid, mem_en, mem_we, mem_wstrb}, '0);
    check("arst_mem_addr", mem_addr, '0);
    check("arst_mem_wdata", mem_wdata, '0);
    check("arst_rdata", {if_rdata, d_rdata}, '0);
    if_req = 1'b0; d_last = '0;
    @(posedge clk); #1;
    clear_logs();
    rst_n = 1'b1; t0 = cyc;
    do_fetch(32'h108);
    check("rst_new_issue_count", issue_log.size(), 1);
    if (issue_log.size() > 0) begin
      check("rst_new_issue_cycle", issue_log[0].cyc - t0, 1);
      check("rst_new_issue_addr", issue_log[0].addr, 32'h108);
    end
    check("rst_new_valid_cycle", at(fv_cyc, 0) - t0, 3);

    // Randomized mixed traffic
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_fetch(32'h100 + 32'(4 * $urandom_range(0, 63)));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          do_data(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(1, 15)));
        end
      end
    join
    repeat (5) @(posedge clk);
    check("sb_drained", f_exp.size() + d_exp.size(), 0);

    // Three-cycle memory latency
    @(posedge clk); #1;
    d3_req = 1'b1; d3_addr = 32'h10; d3_we = 1'b0;
    en_mask = '0; v_at = -1; v_dat = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m3_en) en_mask[k] = 1'b1;
      if (d3_valid) begin v_at = k; v_dat = d3_rdata; end
      @(posedge clk); #1;
      if (v_at >= 0) d3_req = 1'b0;
    end
    check("lat3_mem_en_cycles", en_mask, 8'b0000_0010);
    check("lat3_valid_cycle", v_at, 5);
    check("lat3_rdata", v_dat, init_word(32'h10));
    check("lat3_rdata_hold", d3_rdata, init_word(32'h10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, nfail);
    $finish;
  end

endmodule
